// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// MEM_ARB_LOCK_EN enables locked (atomic) grant sequences.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE      = 2'd0;
  localparam logic [1:0] SZ_HALF      = 2'd1;
  localparam logic [1:0] SZ_UNALIGNED = 2'd2;
  localparam logic [1:0] SZ_WORD      = 2'd3;

  localparam int LOCK_MAX = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
  } mem_req_t;

  function automatic logic req_ok(
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic [15:0] win
  );
    logic al;
    unique case (size)
      SZ_BYTE: al = 1'b1;
      SZ_HALF: al = ~addr[0];
      SZ_WORD: al = (addr[1:0] == 2'b00);
      default: al = 1'b0;
    endcase
    return (addr[31:16] == win) && al;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus bundle for mem_port_arbiter.
// lock_in exists only when MEM_ARB_LOCK_EN is defined.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_in;
  logic [32*NUM_REQ-1:0] addr_in;
  logic [32*NUM_REQ-1:0] wdata_in;
  logic [2*NUM_REQ-1:0]  size_in;
  logic [NUM_REQ-1:0]    we_in;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]    lock_in;
`endif
  logic [NUM_REQ-1:0]    ack_out;
  logic                  err_out;
  logic [31:0]           rdata_out;
  logic [31:0]           mem_addr_out;
  logic [31:0]           mem_wdata_out;
  logic [1:0]            mem_size_out;
  logic                  mem_we_out;
  logic                  mem_re_out;
  logic [31:0]           mem_rdata_in;

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  lock_in,
`endif
    input  req_in, addr_in, wdata_in,
    input  size_in, we_in, mem_rdata_in,
    output ack_out, err_out, rdata_out,
    output mem_addr_out, mem_wdata_out,
    output mem_size_out, mem_we_out, mem_re_out
  );

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output lock_in,
`endif
    output req_in, addr_in, wdata_in,
    output size_in, we_in, mem_rdata_in,
    input  ack_out, err_out, rdata_out,
    input  mem_addr_out, mem_wdata_out,
    input  mem_size_out, mem_we_out, mem_re_out
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational masked round-robin picker.
// Scans from ptr upward (wrapping) for the first unmasked request.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  localparam int PW = IW + 1;

  logic [N-1:0]  elig;
  logic [PW-1:0] pos;

  assign elig = req & ~mask;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(N))
        pos = pos - PW'(N);
      for (int j = 0; j < N; j++) begin
        if (!vld && pos == PW'(j) && elig[j]) begin
          vld    = 1'b1;
          idx    = IW'(j);
          gnt[j] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to add lock_in for atomic locked grant sequences.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input logic clock,
  input logic reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, win_q, win_nxt;
  logic [IW-1:0]      start, pick_idx;
  logic [NUM_REQ-1:0] win_oh_q, mask, pick_gnt;
  logic               pick_vld, keep, ok;
  mem_req_t           sel, cur_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (bus.req_in),
    .mask (mask),
    .ptr  (start),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign win_nxt = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef MEM_ARB_LOCK_EN
  logic [2:0] lock_cnt_q;

  assign keep = (|(bus.lock_in & win_oh_q))
             && (lock_cnt_q < 3'(LOCK_MAX));

  // counts consecutive grants held by the same locked winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      lock_cnt_q <= '0;
    else if (state_q != ST_ACCESS && pick_vld)
      lock_cnt_q <= (state_q == ST_DONE && keep && pick_idx == win_q)
                  ? lock_cnt_q + 3'd1 : 3'd1;
  end
`else
  assign keep = 1'b0;
`endif

  always_comb begin
    mask  = '0;
    start = ptr_q;
    if (state_q == ST_DONE) begin
      start = keep ? win_q : win_nxt;
      mask  = keep ? '0 : win_oh_q;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel.addr  = bus.addr_in[32*i +: 32];
        sel.wdata = bus.wdata_in[32*i +: 32];
        sel.size  = bus.size_in[2*i +: 2];
        sel.we    = bus.we_in[i];
      end
    end
    ok = req_ok(sel.addr, sel.size, MEM_ADDR);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCESS: state_d = ST_DONE;
      ST_IDLE, ST_DONE: begin
        if (pick_vld)
          state_d = ok ? ST_ACCESS : ST_DONE;
        else
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      cur_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DONE && !keep)
        ptr_q <= win_nxt;
      if (state_q != ST_ACCESS && pick_vld) begin
        win_q    <= pick_idx;
        win_oh_q <= pick_gnt;
        cur_q    <= sel;
        err_q    <= ~ok;
      end
      if (state_q == ST_ACCESS && !cur_q.we)
        rdata_q <= bus.mem_rdata_in;
    end
  end

  assign bus.ack_out       = (state_q == ST_DONE) ? win_oh_q : '0;
  assign bus.err_out       = (state_q == ST_DONE) && err_q;
  assign bus.rdata_out     = rdata_q;
  assign bus.mem_addr_out  = cur_q.addr;
  assign bus.mem_wdata_out = cur_q.wdata;
  assign bus.mem_size_out  = cur_q.size;
  assign bus.mem_we_out    = (state_q == ST_ACCESS) && cur_q.we;
  assign bus.mem_re_out    = (state_q == ST_ACCESS) && !cur_q.we;

endmodule
